// File: rtl/pulse_gen_prog.sv
// ---------------------------------------------------------------------------
// pulse_gen_prog
//
// Programmable-period tick generator. Emits a single-cycle pulse every
// period_reg clocks while running. Three run modes:
//   continuous (mode 00) : runs while en=1 and leaves RUN only on load/reset
//   one-shot   (01 / 11) : one pulse after start, then back to IDLE
//   burst      (10)      : burst_len pulses after start (0 means 1)
// The period can be reloaded at any time through load/period_in. A load
// also aborts any run in progress.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-low reset
//   en         count enable; 0 freezes the counter and suppresses pulses
//   mode       run mode select (sampled only when leaving IDLE)
//   start      launch a one-shot or burst run (ignored in continuous mode)
//   burst_len  pulses per burst (sampled only when a burst starts)
//   load       load period_in (0 clamped to 1) and abort any run
//   period_in  new period in clocks
//   pulse_out  single-cycle tick, combinational from state/count/en
//   busy       high while the generator is in RUN
//   done       one-cycle registered flag on one-shot/burst completion
//   count      current counter value
// ---------------------------------------------------------------------------
module pulse_gen_prog #(
  parameter int WIDTH          = 17,
  parameter int DEFAULT_PERIOD = 100000,
  parameter int BURST_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               load,
  input  logic [WIDTH-1:0]   period_in,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0]         MODE_CONT  = 2'b00;
  localparam logic [1:0]         MODE_BURST = 2'b10;
  localparam logic [WIDTH-1:0]   ONE_W      = WIDTH'(1);
  localparam logic [BURST_W-1:0] ONE_B      = BURST_W'(1);
  localparam logic [WIDTH-1:0]   RST_PERIOD = WIDTH'(DEFAULT_PERIOD);

  state_t             state_reg,     state_next;
  logic [WIDTH-1:0]   count_reg,     count_next;
  logic [WIDTH-1:0]   period_reg,    period_next;
  logic [BURST_W-1:0] remaining_reg, remaining_next;
  logic [1:0]         mode_reg,      mode_next;
  logic               done_reg,      done_next;

  // Terminal count: the last cycle of a period. period_reg is never 0,
  // so period_reg-1 cannot underflow.
  logic terminal;
  assign terminal = (state_reg == RUN) && en && (count_reg == period_reg - ONE_W);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      period_reg    <= RST_PERIOD;
      remaining_reg <= '0;
      mode_reg      <= MODE_CONT;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      period_reg    <= period_next;
      remaining_reg <= remaining_next;
      mode_reg      <= mode_next;
      done_reg      <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. load outranks everything except reset; a start that
  // arrives together with load is dropped.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    period_next    = period_reg;
    remaining_next = remaining_reg;
    mode_next      = mode_reg;
    done_next      = 1'b0;

    if (load) begin
      period_next = (period_in == '0) ? ONE_W : period_in;
      count_next  = '0;
      state_next  = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mode == MODE_CONT) begin
            // Continuous mode needs no start; enable alone launches it.
            if (en) begin
              state_next = RUN;
              mode_next  = MODE_CONT;
              count_next = '0;
            end
          end else if (start) begin
            state_next = RUN;
            mode_next  = mode;
            count_next = '0;
            if (mode == MODE_BURST) begin
              remaining_next = (burst_len == '0) ? ONE_B : burst_len;
            end else begin
              remaining_next = ONE_B;
            end
          end
        end

        RUN: begin
          if (en) begin
            if (terminal) begin
              count_next = '0;
              // Only finite runs track remaining pulses; the last one
              // returns to IDLE and raises done for one cycle.
              if (mode_reg != MODE_CONT) begin
                remaining_next = remaining_reg - ONE_B;
                if (remaining_reg == ONE_B) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
                end
              end
            end else begin
              count_next = count_reg + ONE_W;
            end
          end
        end

        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. pulse_out is gated by rst so that it is never seen high in a
  // cycle where reset is being applied.
  // -------------------------------------------------------------------------
  always_comb begin
    pulse_out = rst && terminal;
    busy      = (state_reg == RUN);
    done      = done_reg;
    count     = count_reg;
  end

endmodule

// File: tb/tb_pulse_gen_prog.sv
// ---------------------------------------------------------------------------
// Directed testbench for pulse_gen_prog (WIDTH=8, DEFAULT_PERIOD=10,
// BURST_W=4). Inputs are changed and outputs sampled 1 ns after each rising
// edge; loop index i counts edges since the run was entered.
// ---------------------------------------------------------------------------
module tb_pulse_gen_prog;

  localparam int W  = 8;
  localparam int DP = 10;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic          start;
  logic [BW-1:0] burst_len;
  logic          load;
  logic [W-1:0]  period_in;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_gen_prog #(
    .WIDTH(W),
    .DEFAULT_PERIOD(DP),
    .BURST_W(BW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .start(start),
    .burst_len(burst_len),
    .load(load),
    .period_in(period_in),
    .pulse_out(pulse_out),
    .busy(busy),
    .done(done),
    .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt[17] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 5, 0};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; start = 1'b0;
    burst_len = '0; load = 1'b0; period_in = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", pulse_out, 0);
    check("rst_done", done, 0);

    // ---- continuous, default period 10 ----
    rst = 1'b1; en = 1'b1; mode = 2'b00;
    tick();
    check("cont_entry_busy", busy, 1);
    check("cont_entry_count", count, 0);
    for (int i = 1; i < 30; i++) begin
      tick();
      check("cont_pulse", pulse_out, (i % 10) == 9);
      check("cont_done", done, 0);
      if ((i % 10) == 9) check("cont_term_count", count, 9);
    end

    // ---- one-shot, period 5 (load lands on a terminal-count cycle) ----
    load = 1'b1; period_in = 8'd5; mode = 2'b01;
    tick();
    check("load_busy", busy, 0);
    check("load_count", count, 0);
    load = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("os_entry_busy", busy, 1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("os_pulse", pulse_out, i == 4);
      check("os_done", done, i == 5);
      check("os_busy", busy, i < 5);
      if (i == 5) check("os_count_back", count, 0);
    end

    // ---- mode 11 behaves as one-shot ----
    mode = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("m11_pulse", pulse_out, i == 4);
      check("m11_done", done, i == 5);
    end

    // ---- burst of 3, period 4; start/burst_len changes mid-run ignored ----
    load = 1'b1; period_in = 8'd4; mode = 2'b10;
    tick();
    load = 1'b0; burst_len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check("burst_pulse", pulse_out, ((i % 4) == 3) && (i <= 11));
      check("burst_done", done, i == 12);
      check("burst_busy", busy, i < 12);
      if (i == 5) begin
        start = 1'b1; burst_len = 4'd9;
      end else begin
        start = 1'b0;
      end
    end

    // ---- burst_len 0 gives one pulse ----
    burst_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("b0_pulse", pulse_out, i == 3);
      check("b0_done", done, i == 4);
      check("b0_busy", busy, i < 4);
    end

    // ---- continuous period 6 with en pauses ----
    load = 1'b1; period_in = 8'd6; mode = 2'b00; en = 1'b0;
    tick();
    check("p6_idle_busy", busy, 0);
    load = 1'b0; en = 1'b1;
    tick();
    check("p6_entry_busy", busy, 1);
    check("p6_entry_count", count, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("pause_count", count, exp_cnt[i]);
      check("pause_pulse", pulse_out, (i == 8) || (i == 14));
      if (i == 2) en = 1'b0;
      if (i == 5) en = 1'b1;
      if (i == 14) begin
        en = 1'b0;
        #1;
        check("pause_term_pulse_off", pulse_out, 0);
      end
      if (i == 15) begin
        en = 1'b1;
        #1;
        check("pause_term_pulse_on", pulse_out, 1);
      end
    end

    // ---- load period 0 mid-burst: abort, period becomes 1 ----
    load = 1'b1; period_in = 8'd4; mode = 2'b10;
    tick();
    load = 1'b0; start = 1'b1; burst_len = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("abort_pre_pulse", pulse_out, i == 3);
    end
    load = 1'b1; period_in = 8'd0;
    tick();
    load = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_done2", done, 0);
    check("abort_busy2", busy, 0);
    mode = 2'b00;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("p1_pulse", pulse_out, 1);
      check("p1_count", count, 0);
      tick();
    end

    // ---- reset mid-burst on a terminal-count cycle ----
    load = 1'b1; period_in = 8'd4; mode = 2'b10;
    tick();
    load = 1'b0; start = 1'b1; burst_len = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("prerst_pulse", pulse_out, 1);
    rst = 1'b0;
    #1;
    check("rst_gate_pulse", pulse_out, 0);
    tick();
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pulse", pulse_out, 0);
    check("midrst_done", done, 0);
    rst = 1'b1; mode = 2'b00; en = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("defper_pulse", pulse_out, i == 9);
    end

    // ---- simultaneous start + load: period loads, stays IDLE ----
    mode = 2'b01; load = 1'b1; start = 1'b1; period_in = 8'd3;
    tick();
    check("sl_busy", busy, 0);
    check("sl_count", count, 0);
    load = 1'b0; start = 1'b0;
    tick();
    check("sl_busy2", busy, 0);
    check("sl_pulse", pulse_out, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("sl_os_pulse", pulse_out, i == 2);
      check("sl_os_done", done, i == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_gen_prog.md
Name: pulse_gen_prog

Overview:
Programmable-period tick generator, successor to the fixed 100 000-cycle pulse generator. Emits single-cycle pulses every PERIOD clocks in one of three modes: continuous, one-shot, or burst of N pulses. Period is reloadable at run time, and status outputs (busy, done, count) are exposed. Feeds display multiplexers, debouncers and timed FSMs elsewhere in the design.

Parameters:
WIDTH, 17, counter and period register width in bits
DEFAULT_PERIOD, 100000, period loaded at reset; must satisfy 1 <= DEFAULT_PERIOD <= 2^WIDTH-1
BURST_W, 8, width of burst length input

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset (rst=0 resets on a rising clk edge)
en  input  1  count enable; 0 freezes counter and suppresses pulses
mode  input  2  00 continuous, 01 one-shot, 10 burst, 11 treated as one-shot
start  input  1  launch one-shot/burst (ignored in continuous)
burst_len  input  BURST_W  pulses per burst; 0 treated as 1
load  input  1  load period_in and abort any run
period_in  input  WIDTH  new period in clocks; 0 clamped to 1
pulse_out  output  1  single-cycle tick
busy  output  1  high while state is RUN
done  output  1  registered one-cycle flag on one-shot/burst completion
count  output  WIDTH  current counter value

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, count=0, period_reg=DEFAULT_PERIOD, remaining=0, mode_reg=00, done=0. Outputs pulse_out=0 and busy=0 follow from this state.
- States: IDLE and RUN.
- Priority when several inputs are active in the same cycle: reset > load > start/terminal-count logic.
- load=1: period_reg<=max(period_in,1); count<=0; state<=IDLE; done<=0. Applies in any state and in the same cycle as start; a start in that cycle is dropped.
- IDLE -> RUN:
  - mode=00 with en=1: latch mode_reg=00.
  - mode=01/11 with start=1: latch mode_reg, remaining=1.
  - mode=10 with start=1: latch mode_reg, remaining=max(burst_len,1).
  - In all cases count<=0 on entry.
- RUN, en=0: count holds, pulse_out=0, no state change.
- RUN, en=1, count != period_reg-1: count<=count+1.
- Terminal count (RUN, en=1, count == period_reg-1):
  - pulse_out=1 combinationally in that cycle.
  - count<=0.
  - If mode_reg != 00: remaining<=remaining-1. If remaining==1, state<=IDLE and done<=1 next cycle.
- pulse_out = (state==RUN) & en & (count==period_reg-1). It is never high in IDLE or during reset.
- Latency: start sampled at edge T -> first pulse in cycle T+period_reg. Continuous pulses are spaced exactly period_reg cycles apart.
- period_reg=1: pulse_out high every enabled RUN cycle; count stays 0.
- start while in RUN is ignored. Changes to mode or burst_len during RUN are ignored, since latched values are used.
- Continuous mode leaves RUN only via load or reset. Dropping en only pauses it.
- done is high for exactly one cycle and is cleared the following cycle.
- Counter arithmetic is unsigned modulo 2^WIDTH. It never exceeds period_reg-1, so it never wraps.

Test Plan:
- Default params, mode=00, en=1 after reset: first pulse_out exactly when count=99_999 (cycle 100 000 after RUN entry), repeats every 100 000 cycles; busy=1, done never asserted.
- WIDTH=8, load period_in=5, mode=01, start pulse: exactly one pulse 5 cycles after start, done=1 on the next cycle, busy falls to 0, count returns to 0.
- Burst, period 4, burst_len=3: three pulses spaced 4 cycles apart, done after the third; burst_len=0 yields exactly 1 pulse.
- Continuous mode, period 6, en dropped for 3 cycles mid-count (count=2): count holds at 2, no pulse, then resumes; next pulse is 3 cycles late.
- Load mid-burst with period_in=0: run aborts, busy=0, no done, period_reg=1; a subsequent continuous run pulses every cycle.
- Reset asserted mid-burst (rst=0 for one edge): count=0, busy=0, pulse_out=0, done=0, period_reg back to DEFAULT_PERIOD; simultaneous start+load loads the period and stays IDLE.
